// File: rtl/ser_sched_pkg.sv
// Shared types and constants for the serializer scheduler.
package ser_sched_pkg;

  localparam int DATA_W     = 16;
  localparam int MOD_W      = 4;
  localparam int WDOG_LIMIT = 20;
  localparam int WDOG_W     = 5;

  localparam logic [MOD_W-1:0] MOD_BAD1 = 4'd1;
  localparam logic [MOD_W-1:0] MOD_BAD2 = 4'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Length codes 1 and 2 are too short for the serializer to run.
  function automatic logic mod_ok(input logic [MOD_W-1:0] m);
    return (m != MOD_BAD1) && (m != MOD_BAD2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic          found;
  logic [IW-1:0] idx;

  // First requester at or after ptr (modulo N) wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/ser_sched.sv
// Round-robin scheduler sharing one serializer among N_REQ requesters.
// Handshake: a requester transfers when req_val_i[k] & req_ready_o[k] are
// both high in a cycle; ready is one-hot or zero and only offered in IDLE
// while the serializer is idle. Optional watchdog: SER_SCHED_WDOG_EN.
module ser_sched
  import ser_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ*MOD_W-1:0]  req_mod_i,
  input  logic [N_REQ-1:0]        req_val_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       ser_data_o,
  output logic [MOD_W-1:0]        ser_mod_o,
  output logic                    ser_val_o,
  input  logic                    ser_busy_i,
  output logic [IW-1:0]           grant_id_o,
  output logic [N_REQ-1:0]        err_o,
  output logic                    wdog_o,
  output logic [1:0]              state_o
);

  state_e              state_q;
  logic [IW-1:0]       ptr_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [MOD_W-1:0]    hold_mod_q;
  logic [IW-1:0]       grant_id_q;
  logic [N_REQ-1:0]    arb_gnt;
  logic [IW-1:0]       arb_id;
  logic [IW-1:0]       ptr_next;
  logic [DATA_W-1:0]   sel_data;
  logic [MOD_W-1:0]    sel_mod;
  logic                busy_ok;
  logic                xfer;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req_val_i),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  assign sel_data = req_data_i[arb_id*DATA_W +: DATA_W];
  assign sel_mod  = req_mod_i[arb_id*MOD_W +: MOD_W];
  assign ptr_next = (arb_id == IW'(N_REQ-1)) ? '0 : arb_id + 1'b1;

`ifdef SER_SCHED_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              ign_busy_q;
  logic              wdog_q;
  // After a watchdog abort the stuck busy flag must not block new grants.
  assign busy_ok = !ser_busy_i || ign_busy_q;
  assign wdog_o  = wdog_q;
`else
  assign busy_ok = !ser_busy_i;
  assign wdog_o  = 1'b0;
`endif

  // Ready is the arbiter winner, offered only in IDLE with the serializer
  // free; gated by reset so it is quiet while the block is held in reset.
  always_comb begin
    req_ready_o = '0;
    if (arstn_i && (state_q == S_IDLE) && busy_ok) req_ready_o = arb_gnt;
  end

  assign xfer = |(req_val_i & req_ready_o);

  // Main FSM: capture on transfer, pulse start, wait for busy to drop.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      hold_data_q <= '0;
      hold_mod_q  <= '0;
      grant_id_q  <= '0;
      ser_val_o   <= 1'b0;
      err_o       <= '0;
`ifdef SER_SCHED_WDOG_EN
      wdog_cnt_q  <= '0;
      ign_busy_q  <= 1'b0;
      wdog_q      <= 1'b0;
`endif
    end else begin
      ser_val_o <= 1'b0;
      err_o     <= '0;
`ifdef SER_SCHED_WDOG_EN
      wdog_q    <= 1'b0;
      if (!ser_busy_i) ign_busy_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            hold_data_q <= sel_data;
            hold_mod_q  <= sel_mod;
            grant_id_q  <= arb_id;
            ptr_q       <= ptr_next;
            if (mod_ok(sel_mod)) begin
              state_q   <= S_ISSUE;
              ser_val_o <= 1'b1;
            end else begin
              err_o <= arb_gnt;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef SER_SCHED_WDOG_EN
          wdog_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (!ser_busy_i) begin
            state_q <= S_IDLE;
          end
`ifdef SER_SCHED_WDOG_EN
          else if (wdog_cnt_q == WDOG_W'(WDOG_LIMIT)) begin
            state_q    <= S_IDLE;
            wdog_q     <= 1'b1;
            ign_busy_q <= 1'b1;
            wdog_cnt_q <= '0;
          end else begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ser_data_o = hold_data_q;
  assign ser_mod_o  = hold_mod_q;
  assign grant_id_o = grant_id_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ser_sched.sv
// Directed bench for ser_sched with a simple serializer model.
module tb_ser_sched;
  import ser_sched_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            arstn;
  logic [N*16-1:0] req_data;
  logic [N*4-1:0]  req_mod;
  logic [N-1:0]    req_val;
  logic [N-1:0]    req_ready;
  logic [15:0]     ser_data;
  logic [3:0]      ser_mod;
  logic            ser_val;
  logic            ser_busy;
  logic [1:0]      grant_id;
  logic [N-1:0]    err;
  logic            wdog;
  logic [1:0]      state;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc_n  = 0;
  int   ser_cnt = 0;
  logic busy_force = 1'b0;

  logic [15:0] exp_q[$];
  logic [15:0] mon_data_q[$];
  logic [1:0]  mon_id_q[$];
  int          mon_cyc_q[$];

  ser_sched #(.N_REQ(N)) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .req_data_i  (req_data),
    .req_mod_i   (req_mod),
    .req_val_i   (req_val),
    .req_ready_o (req_ready),
    .ser_data_o  (ser_data),
    .ser_mod_o   (ser_mod),
    .ser_val_o   (ser_val),
    .ser_busy_i  (ser_busy),
    .grant_id_o  (grant_id),
    .err_o       (err),
    .wdog_o      (wdog),
    .state_o     (state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Serializer model: busy for frame-length cycles starting two cycles after
  // the transfer; independent of the scheduler reset.
  always @(posedge clk) begin
    if (ser_val) ser_cnt <= (ser_mod == 4'd0) ? 16 : int'(ser_mod);
    else if (ser_cnt > 0) ser_cnt <= ser_cnt - 1;
  end
  assign ser_busy = (ser_cnt != 0) || busy_force;

  // Start-pulse monitor
  always @(negedge clk) begin
    if (ser_val) begin
      mon_data_q.push_back(ser_data);
      mon_id_q.push_back(grant_id);
      mon_cyc_q.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic set_req(input int k, input logic [15:0] d, input logic [3:0] m);
    req_data[k*16 +: 16] = d;
    req_mod[k*4 +: 4]    = m;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    cyc();
    cyc();
    arstn = 1'b1;
    cyc();
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      if (state == S_IDLE && !ser_busy) break;
      cyc();
    end
    chk(tag, 32'(i < 100), 32'd1);
  endtask

  initial begin
    arstn      = 1'b0;
    req_data   = '0;
    req_mod    = '0;
    req_val    = '0;
    busy_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_ready", req_ready, 0);
    chk("rst_sdata", ser_data, 0);
    chk("rst_smod", ser_mod, 0);
    chk("rst_sval", ser_val, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", err, 0);
    chk("rst_wdog", wdog, 0);
    chk("rst_state", state, S_IDLE);
    arstn = 1'b1;
    cyc();

    // Single requester 0, full-length frame
    set_req(0, 16'hA5C3, 4'd0);
    req_val = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    cyc();
    req_val = 4'b0000;
    #1;
    chk("t1_sval", ser_val, 1);
    chk("t1_sdata", ser_data, 16'hA5C3);
    chk("t1_smod", ser_mod, 0);
    chk("t1_gid", grant_id, 0);
    chk("t1_state_issue", state, S_ISSUE);
    cyc();
    set_req(0, 16'h1111, 4'd0);
    req_val = 4'b0001;
    #1;
    chk("t1_sval_once", ser_val, 0);
    chk("t1_no_grant_busy", req_ready, 0);
    repeat (16) cyc();
    chk("t1_still_wait", state, S_WAIT);
    chk("t1_ready_wait", req_ready, 0);
    cyc();
    chk("t1_idle_b1", state, S_IDLE);
    chk("t1_regrant", req_ready, 4'b0001);
    chk("t1_hold_data", ser_data, 16'hA5C3);
    cyc();
    req_val = 4'b0000;
    chk("t1_sval2", ser_val, 1);
    chk("t1_sdata2", ser_data, 16'h1111);
    wait_idle("t1_wait_idle");

    // All requesters valid, mod 4, from pointer 0
    do_reset();
    mon_data_q.delete();
    mon_id_q.delete();
    mon_cyc_q.delete();
    exp_q.delete();
    for (int k = 0; k < N; k++) set_req(k, 16'h1000 + 16'(k), 4'd4);
    for (int k = 0; k < 5; k++) exp_q.push_back(16'h1000 + 16'(k % N));
    req_val = 4'b1111;
    for (int i = 0; i < 80 && mon_id_q.size() < 5; i++) cyc();
    req_val = 4'b0000;
    chk("t2_pulses", mon_id_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < mon_id_q.size()) begin
        chk($sformatf("t2_id%0d", k), mon_id_q[k], 32'(k % N));
        chk($sformatf("t2_data%0d", k), mon_data_q[k], exp_q[k]);
        if (k > 0) chk($sformatf("t2_gap%0d", k), mon_cyc_q[k] - mon_cyc_q[k-1], 7);
      end
    end
    wait_idle("t2_wait_idle");

    // Rejected length code on 2, valid frame on 3 (pointer is 1 here)
    set_req(2, 16'h2222, 4'd1);
    set_req(3, 16'h3333, 4'd8);
    req_val = 4'b1100;
    #1;
    chk("t3_ready2", req_ready, 4'b0100);
    cyc();
    req_val = 4'b1000;
    #1;
    chk("t3_err", err, 4'b0100);
    chk("t3_no_sval", ser_val, 0);
    chk("t3_state", state, S_IDLE);
    chk("t3_ready3", req_ready, 4'b1000);
    cyc();
    req_val = 4'b0000;
    chk("t3_err_clr", err, 0);
    chk("t3_sval", ser_val, 1);
    chk("t3_gid", grant_id, 3);
    chk("t3_smod", ser_mod, 8);
    chk("t3_sdata", ser_data, 16'h3333);
    wait_idle("t3_wait_idle");

    // Requester 1 withdraws before grant; requester 3 wins (pointer is 0)
    busy_force = 1'b1;
    set_req(1, 16'h4444, 4'd4);
    set_req(3, 16'h5555, 4'd4);
    req_val = 4'b1010;
    #1;
    chk("t6_blocked", req_ready, 0);
    cyc();
    req_val = 4'b1000;
    busy_force = 1'b0;
    #1;
    chk("t6_ready3", req_ready, 4'b1000);
    cyc();
    req_val = 4'b0000;
    chk("t6_sval", ser_val, 1);
    chk("t6_gid", grant_id, 3);
    chk("t6_sdata", ser_data, 16'h5555);
    wait_idle("t6_wait_idle");
    req_val = 4'b1001;
    #1;
    chk("t6_ptr0", req_ready, 4'b0001);
    req_val = 4'b0000;
    #1;

    // Reset in the middle of WAIT with busy high
    set_req(1, 16'h6666, 4'd0);
    req_val = 4'b0010;
    #1;
    cyc();
    req_val = 4'b0000;
    cyc();
    cyc();
    cyc();
    chk("t4_in_wait", state, S_WAIT);
    arstn = 1'b0;
    #1;
    chk("t4_rst_state", state, S_IDLE);
    chk("t4_rst_sdata", ser_data, 0);
    chk("t4_rst_gid", grant_id, 0);
    chk("t4_rst_sval", ser_val, 0);
    cyc();
    arstn = 1'b1;
    set_req(0, 16'h7777, 4'd4);
    req_val = 4'b0001;
    #1;
    chk("t4_no_grant_busy", req_ready, 0);
    begin
      int i;
      for (i = 0; i < 40 && ser_busy; i++) cyc();
      chk("t4_busy_drop", 32'(i < 40), 32'd1);
    end
    chk("t4_regrant", req_ready, 4'b0001);
    cyc();
    req_val = 4'b0000;
    chk("t4_sval", ser_val, 1);
    chk("t4_sdata", ser_data, 16'h7777);
    wait_idle("t4_wait_idle");

    // Busy stuck high after a start (pointer is 1, requester 2 wins)
    set_req(2, 16'h8888, 4'd4);
    req_val = 4'b0100;
    #1;
    cyc();
    req_val = 4'b0000;
    busy_force = 1'b1;
    chk("t5_sval", ser_val, 1);
    repeat (21) cyc();
    chk("t5_wdog_early", wdog, 0);
    chk("t5_wait21", state, S_WAIT);
    cyc();
`ifdef SER_SCHED_WDOG_EN
    chk("t5_wdog_pulse", wdog, 1);
    chk("t5_forced_idle", state, S_IDLE);
`else
    chk("t5_no_wdog", wdog, 0);
    chk("t5_stay_wait", state, S_WAIT);
`endif
    cyc();
    chk("t5_wdog_clr", wdog, 0);
    busy_force = 1'b0;
    wait_idle("t5_wait_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
